// File: rtl/vc_eq_search_unit.sv
// Streaming key search: scan cfg_len words for a key, report first-match index and match count.
// Optional VC_EQ_SEARCH_MASK_EN adds a latched cfg_mask that restricts which bits are compared.
module vc_eq_search_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     cfg_key,
  input  logic [CNT_W-1:0] cfg_len,
`ifdef VC_EQ_SEARCH_MASK_EN
  input  logic [W-1:0]     cfg_mask,
`endif
  output logic             busy,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [W-1:0]     in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_found,
  output logic [CNT_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     key_q, key_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             found_d;
  logic [CNT_W-1:0] index_d, count_d;
  logic             eq_c;
  logic             last_c;

`ifdef VC_EQ_SEARCH_MASK_EN
  logic [W-1:0] mask_q, mask_d;
  assign eq_c = ((in_data ^ key_q) & mask_q) == '0;
`else
  assign eq_c = (in_data == key_q);
`endif

  // len_q is never 0 in SCAN, so len_q-1 cannot underflow there
  assign last_c = (beat_q == len_q - CNT_W'(1));

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    len_d   = len_q;
    beat_d  = beat_q;
    found_d = out_found;
    index_d = out_index;
    count_d = out_count;
`ifdef VC_EQ_SEARCH_MASK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = cfg_key;
          len_d   = cfg_len;
`ifdef VC_EQ_SEARCH_MASK_EN
          mask_d  = cfg_mask;
`endif
          beat_d  = '0;
          found_d = 1'b0;
          index_d = '0;
          count_d = '0;
          state_d = (cfg_len == '0) ? ST_RESP : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (in_val) begin
          beat_d = beat_q + CNT_W'(1);
          if (eq_c) begin
            if (out_count != CNT_MAX) count_d = out_count + CNT_W'(1);
            if (!out_found) begin
              found_d = 1'b1;
              index_d = beat_q;
            end
          end
          if (last_c) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_rdy) begin
          found_d = 1'b0;
          index_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
`ifdef VC_EQ_SEARCH_MASK_EN
      mask_q    <= '0;
`endif
      busy      <= 1'b0;
      in_rdy    <= 1'b0;
      out_val   <= 1'b0;
      out_found <= 1'b0;
      out_index <= '0;
      out_count <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
`ifdef VC_EQ_SEARCH_MASK_EN
      mask_q    <= mask_d;
`endif
      busy      <= (state_d != ST_IDLE);
      in_rdy    <= (state_d == ST_SCAN);
      out_val   <= (state_d == ST_RESP);
      out_found <= found_d;
      out_index <= index_d;
      out_count <= count_d;
    end
  end

endmodule

// File: tb/tb_vc_eq_search_unit.sv
// Randomized bench for vc_eq_search_unit: a transaction-level model predicts phase and result.
`timescale 1ns/1ps
module tb_vc_eq_search_unit;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 16;
  localparam int PH_IDLE = 0, PH_SCAN = 1, PH_RESP = 2;

  typedef struct packed {
    logic             found;
    logic [CNT_W-1:0] index;
    logic [CNT_W-1:0] count;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [W-1:0]     cfg_key = '0;
  logic [CNT_W-1:0] cfg_len = '0;
`ifdef VC_EQ_SEARCH_MASK_EN
  logic [W-1:0]     cfg_mask = '0;
`endif
  logic             busy, in_rdy, out_val, out_found;
  logic             in_val = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             out_rdy = 1'b0;
  logic [CNT_W-1:0] out_index, out_count;

  vc_eq_search_unit #(.W(W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_key(cfg_key), .cfg_len(cfg_len),
`ifdef VC_EQ_SEARCH_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .busy(busy), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_found(out_found),
    .out_index(out_index), .out_count(out_count)
  );

  // Narrow instance used only to exercise the count saturation limit
  logic         s_start = 1'b0, s_in_val = 1'b0, s_out_rdy = 1'b0;
  logic [W-1:0] s_key = '0, s_in_data = '0;
  logic [1:0]   s_len = '0;
  logic         s_busy, s_in_rdy, s_out_val, s_found;
  logic [1:0]   s_index, s_count;
`ifdef VC_EQ_SEARCH_MASK_EN
  logic [W-1:0] s_mask = '1;
`endif

  vc_eq_search_unit #(.W(W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .start(s_start), .cfg_key(s_key), .cfg_len(s_len),
`ifdef VC_EQ_SEARCH_MASK_EN
    .cfg_mask(s_mask),
`endif
    .busy(s_busy), .in_val(s_in_val), .in_rdy(s_in_rdy), .in_data(s_in_data),
    .out_val(s_out_val), .out_rdy(s_out_rdy), .out_found(s_found),
    .out_index(s_index), .out_count(s_count)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   phase = PH_IDLE;
  res_t exp_q[$];

  // Expected result straight from the matching rules; mask of all ones is plain equality
  function automatic res_t model(input logic [W-1:0] key, input logic [W-1:0] mask,
                                 input logic [W-1:0] d[$]);
    res_t r = '0;
    foreach (d[i]) begin
      if (((d[i] ^ key) & mask) == '0) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.index = CNT_W'(i);
        end
        if (r.count != '1) r.count = r.count + CNT_W'(1);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the bench's own view of the transaction phase
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outs", 64'({busy, in_rdy, out_val, out_found, out_index, out_count}), 64'd0);
    end else if (phase == PH_IDLE) begin
      check("idle_outs", 64'({busy, in_rdy, out_val, out_found, out_index, out_count}), 64'd0);
    end else if (phase == PH_SCAN) begin
      check("scan_hs", 64'({busy, in_rdy, out_val}), 64'b110);
    end else begin
      check("resp_hs", 64'({busy, in_rdy, out_val}), 64'b101);
      if (exp_q.size() == 0) begin
        check("resp_queue_empty", 64'd1, 64'd0);
      end else begin
        check("result", 64'({out_found, out_index, out_count}), 64'(exp_q[0]));
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // mode: 0 = in_val always 1, 1 = toggling 1/0, 2 = random bubbles
  task automatic search(input logic [W-1:0] key, input logic [W-1:0] mask,
                        input logic [W-1:0] d[$], input int mode, input int hold);
    int i = 0;
    int cyc = 0;
    start   = 1'b1;
    cfg_key = key;
    cfg_len = CNT_W'(d.size());
`ifdef VC_EQ_SEARCH_MASK_EN
    cfg_mask = mask;
`endif
    exp_q.push_back(model(key, mask, d));
    @(posedge clk); #1;
    start   = 1'b0;
    cfg_key = $urandom;
    phase   = (d.size() == 0) ? PH_RESP : PH_SCAN;
    while (phase == PH_SCAN) begin
      case (mode)
        0:       in_val = 1'b1;
        1:       in_val = (cyc % 2) == 0;
        default: in_val = $urandom_range(2) != 0;
      endcase
      in_data = in_val ? d[i] : $urandom;
      if ($urandom_range(4) == 0) begin
        start   = 1'b1;
        cfg_len = CNT_W'($urandom_range(9));
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (in_val) begin
        i++;
        if (i == d.size()) phase = PH_RESP;
      end
    end
    in_val  = 1'($urandom_range(1));
    in_data = $urandom;
    out_rdy = 1'b0;
    repeat (hold) begin
      start = 1'($urandom_range(1));
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    in_val  = 1'b0;
    phase   = PH_IDLE;
  endtask

  initial begin
    logic [W-1:0] d[$];
    logic [W-1:0] key, mask;
    res_t r;

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Saturation at CNT_W=2: three matches give the maximum count, never wrap
    s_start = 1'b1; s_key = 32'h7; s_len = 2'd3;
    @(posedge clk); #1;
    s_start = 1'b0; s_in_val = 1'b1; s_in_data = 32'h7;
    repeat (3) @(posedge clk);
    #1 s_in_val = 1'b0;
    check("sat_out_val", 64'(s_out_val), 64'd1);
    check("sat_result", 64'({s_found, s_index, s_count}), 64'({1'b1, 2'd0, 2'd3}));
    s_out_rdy = 1'b1;
    @(posedge clk); #1;
    s_out_rdy = 1'b0;
    check("sat_idle", 64'({s_busy, s_out_val, s_count}), 64'd0);

    // Basic search with two hits; the model itself is pinned to hand values
    d = '{32'h1, 32'hDEADBEEF, 32'h2, 32'hDEADBEEF};
    r = model(32'hDEADBEEF, '1, d);
    check("model_t1", 64'(r), 64'({1'b1, 16'd1, 16'd2}));
    search(32'hDEADBEEF, '1, d, 0, 0);

    // Zero length goes straight to the response
    d = {};
    search(32'h1234, '1, d, 0, 1);

    // Toggling valid, held response, ignored starts while busy
    d = '{32'hA, 32'hB, 32'hA};
    r = model(32'hB, '1, d);
    check("model_t3", 64'(r), 64'({1'b1, 16'd1, 16'd1}));
    search(32'hB, '1, d, 1, 5);

    // Reset in the middle of a scan discards the partial result
    start = 1'b1; cfg_key = 32'h5; cfg_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; phase = PH_SCAN; in_val = 1'b1; in_data = 32'h5;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    in_val = 1'b0;
    phase = PH_IDLE;
    #1 check("async_reset", 64'({busy, in_rdy, out_val, out_found, out_index, out_count}), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    d = '{32'h5};
    r = model(32'h5, '1, d);
    check("model_t5", 64'(r), 64'({1'b1, 16'd0, 16'd1}));
    search(32'h5, '1, d, 0, 0);

    // Partial-key match only counts when the mask hides the differing bits
    d = '{32'hABCDFFFF};
`ifdef VC_EQ_SEARCH_MASK_EN
    mask = 32'h0000FFFF;
    check("model_t6", 64'(model(32'h0000FFFF, mask, d)), 64'({1'b1, 16'd0, 16'd1}));
`else
    mask = '1;
    check("model_t6", 64'(model(32'h0000FFFF, mask, d)), 64'd0);
`endif
    search(32'h0000FFFF, mask, d, 0, 0);

    // Randomized back-to-back searches
    for (int n = 0; n < 40; n++) begin
      key = $urandom;
`ifdef VC_EQ_SEARCH_MASK_EN
      mask = ($urandom_range(3) == 0) ? '0 : W'($urandom);
`else
      mask = '1;
`endif
      d = {};
      for (int k = 0; k < int'($urandom_range(12)); k++)
        d.push_back(($urandom_range(2) == 0) ? (key ^ (W'($urandom) & ~mask)) : W'($urandom));
      search(key, mask, d, int'($urandom_range(2)), int'($urandom_range(3)));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
